// File: rtl/coarse_gain_autorange_ctrl.sv
// Autoranging controller for the coarse gain/limiter stage: measures per-window saturation and
// headroom at the current gain and steps log2_gain up or down one octave between windows.
module coarse_gain_autorange_ctrl #(
    parameter int INPUT_WIDTH     = 16,
    parameter int MAX_LOG2_GAIN   = 3,
    parameter int WIDTH_LOG2_GAIN = 2,
    parameter int WINDOW_WIDTH    = 16,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic [WIDTH_LOG2_GAIN-1:0] manual_gain_i,
    input  logic [WINDOW_WIDTH-1:0]    window_len_i,
    input  logic [WINDOW_WIDTH-1:0]    sat_limit_i,
    input  logic [INPUT_WIDTH-1:0]     data_i,
    input  logic                       valid_i,
    output logic [WIDTH_LOG2_GAIN-1:0] log2_gain_o,
    output logic                       gain_update_o,
    output logic [WINDOW_WIDTH-1:0]    sat_count_o,
    output logic [1:0]                 state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_SETTLE  = 2'd3
    } state_e;

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH_LOG2_GAIN-1:0] GAIN_MAX = WIDTH_LOG2_GAIN'(MAX_LOG2_GAIN);

    state_e                     state_q, state_d;
    logic [WIDTH_LOG2_GAIN-1:0] gain_q, gain_d;
    logic                       update_q, update_d;
    logic [WINDOW_WIDTH-1:0]    sat_out_q, sat_out_d;
    logic [WINDOW_WIDTH-1:0]    len_q, len_d;
    logic [WINDOW_WIDTH-1:0]    samp_cnt_q, samp_cnt_d;
    logic [WINDOW_WIDTH-1:0]    sat_cnt_q, sat_cnt_d;
    logic [WINDOW_WIDTH-1:0]    small_cnt_q, small_cnt_d;
    logic [SETTLE_W-1:0]        settle_q, settle_d;

    logic                       sample_sat;
    logic                       sample_small;
    logic                       clear_cnt;
    logic [WIDTH_LOG2_GAIN-1:0] manual_clamped;
    logic [WINDOW_WIDTH-1:0]    len_start;
    logic                       unused_data;

    // Only the top MAX_LOG2_GAIN+2 bits decide sat/small; the rest are folded here.
    assign unused_data = ^data_i;

    function automatic logic [WINDOW_WIDTH-1:0] sat_inc(input logic [WINDOW_WIDTH-1:0] v);
        return (v == '1) ? v : v + WINDOW_WIDTH'(1);
    endfunction

    assign manual_clamped = (int'(manual_gain_i) > MAX_LOG2_GAIN) ? GAIN_MAX : manual_gain_i;
    assign len_start      = (window_len_i == '0) ? WINDOW_WIDTH'(1) : window_len_i;

    // A sample saturates when any of the g bits shifted out differ from the sign; it is small
    // when one more shift would still keep every dropped bit equal to the sign.
    always_comb begin
        sample_sat   = 1'b0;
        sample_small = (gain_q != GAIN_MAX);
        for (int i = 1; i <= MAX_LOG2_GAIN + 1; i++) begin
            if (data_i[INPUT_WIDTH-1-i] != data_i[INPUT_WIDTH-1]) begin
                if (i <= int'(gain_q))     sample_sat   = 1'b0 | 1'b1;
                if (i <= int'(gain_q) + 1) sample_small = 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        gain_d      = gain_q;
        sat_out_d   = sat_out_q;
        len_d       = len_q;
        samp_cnt_d  = samp_cnt_q;
        sat_cnt_d   = sat_cnt_q;
        small_cnt_d = small_cnt_q;
        settle_d    = settle_q;
        clear_cnt   = 1'b0;

        if (!enable_i) begin
            state_d   = ST_IDLE;
            gain_d    = manual_clamped;
            clear_cnt = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    gain_d    = manual_clamped;
                    state_d   = ST_MEASURE;
                    len_d     = len_start;
                    clear_cnt = 1'b1;
                end
                ST_MEASURE: begin
                    if (valid_i) begin
                        samp_cnt_d = sat_inc(samp_cnt_q);
                        if (sample_sat)   sat_cnt_d   = sat_inc(sat_cnt_q);
                        if (sample_small) small_cnt_d = sat_inc(small_cnt_q);
                        if (samp_cnt_d == len_q) state_d = ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    sat_out_d = sat_cnt_q;
                    clear_cnt = 1'b1;
                    if (sat_cnt_q > sat_limit_i && gain_q != '0) begin
                        gain_d  = gain_q - WIDTH_LOG2_GAIN'(1);
                        state_d = ST_SETTLE;
                    end else if (small_cnt_q == len_q && gain_q != GAIN_MAX) begin
                        gain_d  = gain_q + WIDTH_LOG2_GAIN'(1);
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_MEASURE;
                        len_d   = len_start;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d   = ST_MEASURE;
                        len_d     = len_start;
                        clear_cnt = 1'b1;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
            endcase
        end

        if (clear_cnt) begin
            samp_cnt_d  = '0;
            sat_cnt_d   = '0;
            small_cnt_d = '0;
            settle_d    = '0;
        end
    end

    assign update_d = (gain_d != gain_q);

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            gain_q      <= '0;
            update_q    <= 1'b0;
            sat_out_q   <= '0;
            len_q       <= '0;
            samp_cnt_q  <= '0;
            sat_cnt_q   <= '0;
            small_cnt_q <= '0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            update_q    <= update_d;
            sat_out_q   <= sat_out_d;
            len_q       <= len_d;
            samp_cnt_q  <= samp_cnt_d;
            sat_cnt_q   <= sat_cnt_d;
            small_cnt_q <= small_cnt_d;
            settle_q    <= settle_d;
        end
    end

    assign log2_gain_o   = gain_q;
    assign gain_update_o = update_q;
    assign sat_count_o   = sat_out_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_coarse_gain_autorange_ctrl.sv
// Directed bench for coarse_gain_autorange_ctrl: expected gain steps are queued as stimulus is
// applied and popped when the controller pulses gain_update_o.
module tb_coarse_gain_autorange_ctrl;

    typedef struct {
        logic [1:0]  gain;
        logic [15:0] sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  manual_gain;
    logic [15:0] window_len;
    logic [15:0] sat_limit;
    logic [15:0] data;
    logic        valid;
    logic [1:0]  log2_gain;
    logic        gain_update;
    logic [15:0] sat_count;
    logic [1:0]  state;

    logic        enable5;
    logic [2:0]  manual5;
    logic [15:0] len5;
    logic [15:0] lim5;
    logic [15:0] data5;
    logic        valid5;
    logic [2:0]  gain5;
    logic        upd5;
    logic [15:0] sat5;
    logic [1:0]  state5;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    logic [15:0] win_a [4] = '{16'h7000, 16'h7000, 16'h0010, 16'h0010};

    always #5 clk = ~clk;

    coarse_gain_autorange_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .manual_gain_i (manual_gain),
        .window_len_i  (window_len),
        .sat_limit_i   (sat_limit),
        .data_i        (data),
        .valid_i       (valid),
        .log2_gain_o   (log2_gain),
        .gain_update_o (gain_update),
        .sat_count_o   (sat_count),
        .state_o       (state)
    );

    coarse_gain_autorange_ctrl #(
        .WIDTH_LOG2_GAIN (3),
        .MAX_LOG2_GAIN   (5)
    ) dut5 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable5),
        .manual_gain_i (manual5),
        .window_len_i  (len5),
        .sat_limit_i   (lim5),
        .data_i        (data5),
        .valid_i       (valid5),
        .log2_gain_o   (gain5),
        .gain_update_o (upd5),
        .sat_count_o   (sat5),
        .state_o       (state5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] g, input logic [15:0] s);
        exp_t e;
        e.gain = g;
        e.sat  = s;
        sb_q.push_back(e);
    endtask

    // Ticks until a gain pulse (bounded), then checks latency and pops the expected result.
    task automatic wait_pulse(input string tag, input int lat);
        int   n;
        exp_t e;
        n = 0;
        do begin
            tick();
            n++;
        end while (gain_update !== 1'b1 && n < lat + 8);
        check({tag, "_pulse"}, 32'(gain_update), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        if (sb_q.size() == 0) begin
            check({tag, "_sb"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_gain"}, 32'(log2_gain), 32'(e.gain));
            check({tag, "_satc"}, 32'(sat_count), 32'(e.sat));
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (gain_update === 1'b1) pulses++;
        end
        check({tag, "_nopulse"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;  enable = 1'b0;  manual_gain = 2'd0;
        window_len = 16'd8;  sat_limit = 16'd0;  data = 16'h0000;  valid = 1'b0;
        enable5 = 1'b0;  manual5 = 3'd0;  len5 = 16'd1;  lim5 = 16'd0;
        data5 = 16'h0000;  valid5 = 1'b0;

        #12;
        check("rst_gain", 32'(log2_gain), 32'd0);
        check("rst_upd", 32'(gain_update), 32'd0);
        check("rst_satc", 32'(sat_count), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_gain5", 32'(gain5), 32'd0);
        #6 rst_n = 1'b1;
        tick();

        // Manual path on the wider instance: apply 5, then 7 clamps to MAX=5
        manual5 = 3'd5;
        tick();
        check("man5_gain", 32'(gain5), 32'd5);
        check("man5_upd", 32'(upd5), 32'd1);
        tick();
        check("man5_upd_clr", 32'(upd5), 32'd0);
        manual5 = 3'd7;
        tick();
        check("man7_clamp", 32'(gain5), 32'd5);
        check("man7_noupd", 32'(upd5), 32'd0);

        // Climb 0->1->2->3 on small samples, then hold at MAX
        window_len = 16'd8;  sat_limit = 16'd0;  data = 16'h0100;  valid = 1'b1;
        enable = 1'b1;
        push(2'd1, 16'd0);  push(2'd2, 16'd0);  push(2'd3, 16'd0);
        wait_pulse("up1", 10);
        check("up1_state", 32'(state), 32'd3);
        wait_pulse("up2", 13);
        wait_pulse("up3", 13);
        quiet("hold_settle", 12);
        check("hold_decide", 32'(state), 32'd2);
        quiet("hold_dec", 1);
        check("hold_meas", 32'(state), 32'd1);
        check("hold_gain", 32'(log2_gain), 32'd3);
        quiet("hold_win2", 9);

        // Back to IDLE keeping gain 3
        valid = 1'b0;  manual_gain = 2'd3;  enable = 1'b0;
        tick();
        check("idle3_state", 32'(state), 32'd0);
        check("idle3_upd", 32'(gain_update), 32'd0);

        // Two saturating samples over limit 1 -> step down
        window_len = 16'd4;  sat_limit = 16'd1;  enable = 1'b1;
        tick();
        check("dn_meas", 32'(state), 32'd1);
        push(2'd2, 16'd2);
        for (int i = 0; i < 4; i++) begin
            data = win_a[i];  valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        check("dn_decide", 32'(state), 32'd2);
        wait_pulse("down", 1);
        check("down_state", 32'(state), 32'd3);

        // Limit 2 with the same samples: hold at 3
        enable = 1'b0;
        push(2'd3, 16'd2);
        wait_pulse("man3", 1);
        sat_limit = 16'd2;  enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            data = win_a[i];  valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        check("hl_decide", 32'(state), 32'd2);
        quiet("hl", 1);
        check("hl_meas", 32'(state), 32'd1);
        check("hl_gain", 32'(log2_gain), 32'd3);
        check("hl_satc", 32'(sat_count), 32'd2);

        // Abort a partial window (3 saturating samples) by disabling
        data = 16'h7000;  valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("ab_meas", 32'(state), 32'd1);
        valid = 1'b0;  manual_gain = 2'd1;  enable = 1'b0;
        push(2'd1, 16'd2);
        wait_pulse("abort", 1);
        check("abort_state", 32'(state), 32'd0);

        // Negative full-scale at g=0: no change, sat count rewritten to 0
        manual_gain = 2'd0;
        push(2'd0, 16'd2);
        wait_pulse("man0", 1);
        window_len = 16'd4;  sat_limit = 16'd0;  data = 16'h8000;  valid = 1'b1;
        enable = 1'b1;
        quiet("neg", 11);
        check("neg_state", 32'(state), 32'd1);
        check("neg_gain", 32'(log2_gain), 32'd0);
        check("neg_satc", 32'(sat_count), 32'd0);

        // Valid toggling: decision one clock after the 4th valid sample
        valid = 1'b0;  enable = 1'b0;
        tick();
        check("tg_idle", 32'(state), 32'd0);
        data = 16'h0100;  enable = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            valid = (i % 2 == 0);
            tick();
        end
        check("tg_meas", 32'(state), 32'd1);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("tg_decide", 32'(state), 32'd2);
        push(2'd1, 16'd0);
        wait_pulse("toggle", 1);

        // Window length 0 behaves as 1
        enable = 1'b0;
        push(2'd0, 16'd0);
        wait_pulse("man0b", 1);
        window_len = 16'd0;  data = 16'h0100;  valid = 1'b1;  enable = 1'b1;
        push(2'd1, 16'd0);
        wait_pulse("len0", 3);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #2;
        check("arst_gain", 32'(log2_gain), 32'd0);
        check("arst_upd", 32'(gain_update), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        check("arst_gain5", 32'(gain5), 32'd0);
        enable = 1'b0;  valid = 1'b0;
        #3 rst_n = 1'b1;
        tick();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
